// File: rtl/standalone_hps_buttons_irq_ctrl.sv
// ---------------------------------------------------------------------------
// standalone_hps_buttons_irq_ctrl
//
// Avalon-MM slave for the board push-buttons, sitting between the raw button
// pins and the HPS lightweight bridge. Each button bit is synchronised,
// debounced and watched for press edges. Captured presses raise a maskable,
// level-sensitive interrupt, so software does not have to poll.
//
// Ports
//   clk         system clock (single domain)
//   reset       asynchronous, active-high reset
//   chipselect  Avalon slave select; qualifies read and write
//   address     word address: 0 DATA, 1 MASK, 2 EDGE, 3 RAW
//   read        read strobe (reads have no side effects)
//   write       write strobe
//   writedata   write data (only [WIDTH-1:0] is meaningful)
//   readdata    registered read data, one cycle after the address
//   in_port     raw button pins, active-low (pressed = 0), asynchronous
//   irq         registered level interrupt
//
// Register map (unused bits read as 0, writes to RO registers are ignored)
//   0 DATA  RO    debounced level, 1 = pressed
//   1 MASK  RW    per-bit interrupt enable
//   2 EDGE  RW1C  captured press edges; writing 1 clears that bit
//   3 RAW   RO    synchronised but undebounced level, 1 = pressed
// ---------------------------------------------------------------------------
module standalone_hps_buttons_irq_ctrl #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             chipselect,
  input  logic [1:0]       address,
  input  logic             read,
  input  logic             write,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd1;
  localparam logic [1:0] ADDR_EDGE = 2'd2;
  localparam logic [1:0] ADDR_RAW  = 2'd3;

  // Count value at which a persistent mismatch is accepted as the new level.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Synchroniser and debounce state. Idle (released) pins are high, so the
  // level-tracking flops reset to all-ones: releasing reset with buttons
  // idle cannot look like a press.
  logic [WIDTH-1:0]            sync1_q;
  logic [WIDTH-1:0]            sync2_q;
  logic [WIDTH-1:0]            stable_q, stable_d;
  logic [WIDTH-1:0][CNT_W-1:0] cnt_q,    cnt_d;

  // Software-visible state.
  logic [WIDTH-1:0]            mask_q,   mask_d;
  logic [WIDTH-1:0]            edge_q,   edge_d;
  logic [31:0]                 readdata_q, readdata_d;
  logic                        irq_q,    irq_d;

  // Decoded bus strobes and press detection.
  logic                        wr_en;
  logic [WIDTH-1:0]            edge_clr;
  logic [WIDTH-1:0]            press;

  // The read strobe carries no side effects and writedata is only partly
  // decoded; fold the leftovers into one sink so they are visibly unused.
  logic                        unused_ok;
  assign unused_ok = &{1'b0, read, writedata};

  // -------------------------------------------------------------------------
  // Debounce: a bit's counter runs only while the synchronised level differs
  // from the accepted level. Any return to the accepted level zeroes the
  // counter, so a glitch shorter than DEBOUNCE_CYCLES is discarded entirely.
  // -------------------------------------------------------------------------
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          stable_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // A press is the accepted level falling 1 -> 0. Using stable_d lets the
  // capture bit set on the same edge the new level is accepted.
  assign press = stable_q & ~stable_d;

  // -------------------------------------------------------------------------
  // Bus decode and register next-state
  // -------------------------------------------------------------------------
  assign wr_en    = chipselect & write;
  assign edge_clr = (wr_en && address == ADDR_EDGE) ? writedata[WIDTH-1:0] : '0;

  always_comb begin
    mask_d = mask_q;
    if (wr_en && address == ADDR_MASK) begin
      mask_d = writedata[WIDTH-1:0];
    end
  end

  // Set has priority over W1C so a press arriving in the same cycle as the
  // clear of that bit is never lost.
  assign edge_d = (edge_q & ~edge_clr) | press;

  // The interrupt looks at the registered capture and mask, so it follows a
  // capture, clear or mask change by exactly one cycle.
  assign irq_d = |(edge_q & mask_q);

  // Read mux runs every cycle regardless of read; the result is registered,
  // giving a fixed one-cycle read latency.
  always_comb begin
    readdata_d = '0;
    unique case (address)
      ADDR_DATA: readdata_d[WIDTH-1:0] = ~stable_q;
      ADDR_MASK: readdata_d[WIDTH-1:0] = mask_q;
      ADDR_EDGE: readdata_d[WIDTH-1:0] = edge_q;
      ADDR_RAW:  readdata_d[WIDTH-1:0] = ~sync2_q;
      default:   readdata_d            = '0;
    endcase
  end

  // -------------------------------------------------------------------------
  // State registers. The two synchroniser flops have nothing between them.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q    <= '1;
      sync2_q    <= '1;
      stable_q   <= '1;
      cnt_q      <= '0;
      mask_q     <= '0;
      edge_q     <= '0;
      readdata_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      sync1_q    <= in_port;
      sync2_q    <= sync1_q;
      stable_q   <= stable_d;
      cnt_q      <= cnt_d;
      mask_q     <= mask_d;
      edge_q     <= edge_d;
      readdata_q <= readdata_d;
      irq_q      <= irq_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule
